cnn_layer_scheduler: RTL and testbench



---
 rtl/cnn_layer_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_cnn_layer_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: steps the conv / max-pool engines through a small
// programmed layer table. Each layer is loaded onto the engine config
// outputs, the selected engine is given a one-cycle enable, and the
// scheduler waits for a rising edge of that engine's picture-finish.
// Optional feature macro: SCHED_TIMEOUT_EN adds a per-layer watchdog that
// gives up after TIMEOUT_CYCLES cycles in WAIT.
module cnn_layer_scheduler #(
    parameter int MEMADDRBIT     = 14,
    parameter int NUM_LAYERS     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_idx,
    input  logic [3:0]            cfg_field,
    input  logic [MEMADDRBIT-1:0] cfg_data,
    input  logic [3:0]            last_layer,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  sched_done,
    output logic                  err,
    output logic [3:0]            cur_layer,
    output logic                  eng_sel,
    output logic                  conv_enable,
    output logic                  pool_enable,
    input  logic                  eng_done,
    output logic [2:0]            step,
    output logic [MEMADDRBIT-1:0] dr,
    output logic [MEMADDRBIT-1:0] dc,
    output logic [MEMADDRBIT-1:0] di,
    output logic [MEMADDRBIT-1:0] dr_out,
    output logic [MEMADDRBIT-1:0] dc_out,
    output logic [MEMADDRBIT-1:0] di_out,
    output logic [MEMADDRBIT-1:0] inaddr,
    output logic [MEMADDRBIT-1:0] outaddr
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    // Elaboration-time sanity checks on the configuration.
    if (NUM_LAYERS < 1 || NUM_LAYERS > 16) begin : g_bad_layers
        $error("NUM_LAYERS must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, NEXT} state_t;

    typedef struct packed {
        logic                  typ;      // 0 = conv, 1 = max-pool
        logic [2:0]            step;
        logic [MEMADDRBIT-1:0] dr, dc, di;
        logic [MEMADDRBIT-1:0] dr_out, dc_out, di_out;
        logic [MEMADDRBIT-1:0] inaddr, outaddr;
    } layer_cfg_t;

    state_t     state, state_next;
    layer_cfg_t table_q [NUM_LAYERS];
    layer_cfg_t cfg_q;
    logic [3:0] last_q;
    logic       done_q;
    logic       done_rise;
    logic       tbl_we;

    logic do_start, do_reject, do_load, do_issue, do_advance, do_finish;
    logic do_clear, do_timeout, wd_expired;

    assign done_rise = eng_done && !done_q;
    assign tbl_we    = cfg_we && !busy && ({1'b0, cfg_idx} < 5'(NUM_LAYERS)) && (cfg_field <= 4'd8);

`ifdef SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wd_cnt;

    // Watchdog: cleared on the way into WAIT, counts every cycle spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst)                wd_cnt <= '0;
        else if (state == ISSUE) wd_cnt <= '0;
        else if (state == WAIT)  wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle action decode; abort outranks everything else.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_next = state;
        do_start   = 1'b0;
        do_reject  = 1'b0;
        do_load    = 1'b0;
        do_issue   = 1'b0;
        do_advance = 1'b0;
        do_finish  = 1'b0;
        do_clear   = 1'b0;
        do_timeout = 1'b0;
        if (abort && state != IDLE) begin
            do_clear   = 1'b1;
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if ({1'b0, last_layer} < 5'(NUM_LAYERS)) begin
                            do_start   = 1'b1;
                            state_next = LOAD;
                        end else begin
                            do_reject  = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    do_load    = 1'b1;
                    state_next = ISSUE;
                end
                ISSUE: begin
                    do_issue   = 1'b1;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (done_rise) begin
                        state_next = NEXT;
                    end else if (wd_expired) begin
                        do_clear   = 1'b1;
                        do_timeout = 1'b1;
                        state_next = IDLE;
                    end
                end
                NEXT: begin
                    if (cur_layer == last_q) begin
                        do_finish  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        do_advance = 1'b1;
                        state_next = LOAD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Table writes, registered engine outputs and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the layer table is cleared on reset, so it is a loop of
            // flops rather than a RAM; keep NUM_LAYERS small.
            for (int i = 0; i < NUM_LAYERS; i++) table_q[i] <= '0;
            cfg_q       <= '0;
            last_q      <= '0;
            done_q      <= 1'b0;
            busy        <= 1'b0;
            cur_layer   <= '0;
            conv_enable <= 1'b0;
            pool_enable <= 1'b0;
            sched_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            done_q      <= eng_done;
            conv_enable <= 1'b0;
            pool_enable <= 1'b0;
            sched_done  <= 1'b0;
            err         <= do_reject || do_timeout;

            if (tbl_we) begin
                case (cfg_field)
                    4'd0: begin
                        table_q[cfg_idx[IDX_W-1:0]].typ  <= cfg_data[0];
                        table_q[cfg_idx[IDX_W-1:0]].step <= cfg_data[3:1];
                    end
                    4'd1:    table_q[cfg_idx[IDX_W-1:0]].dr      <= cfg_data;
                    4'd2:    table_q[cfg_idx[IDX_W-1:0]].dc      <= cfg_data;
                    4'd3:    table_q[cfg_idx[IDX_W-1:0]].di      <= cfg_data;
                    4'd4:    table_q[cfg_idx[IDX_W-1:0]].dr_out  <= cfg_data;
                    4'd5:    table_q[cfg_idx[IDX_W-1:0]].dc_out  <= cfg_data;
                    4'd6:    table_q[cfg_idx[IDX_W-1:0]].di_out  <= cfg_data;
                    4'd7:    table_q[cfg_idx[IDX_W-1:0]].inaddr  <= cfg_data;
                    default: table_q[cfg_idx[IDX_W-1:0]].outaddr <= cfg_data;
                endcase
            end

            if (do_start) begin
                last_q    <= last_layer;
                cur_layer <= '0;
                busy      <= 1'b1;
            end
            if (do_load)    cfg_q     <= table_q[cur_layer[IDX_W-1:0]];
            if (do_issue) begin
                conv_enable <= !cfg_q.typ;
                pool_enable <= cfg_q.typ;
            end
            if (do_advance) cur_layer <= cur_layer + 1'b1;
            if (do_finish) begin
                sched_done <= 1'b1;
                busy       <= 1'b0;
            end
            if (do_clear) begin
                busy      <= 1'b0;
                cur_layer <= '0;
                cfg_q     <= '0;
            end
        end
    end

    assign eng_sel = cfg_q.typ;
    assign step    = cfg_q.step;
    assign dr      = cfg_q.dr;
    assign dc      = cfg_q.dc;
    assign di      = cfg_q.di;
    assign dr_out  = cfg_q.dr_out;
    assign dc_out  = cfg_q.dc_out;
    assign di_out  = cfg_q.di_out;
    assign inaddr  = cfg_q.inaddr;
    assign outaddr = cfg_q.outaddr;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed testbench for cnn_layer_scheduler. Inputs change 1 ns after the
// rising edge; outputs are read at the same point, after they have settled.
module tb_cnn_layer_scheduler;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_we;
    logic [3:0]   cfg_idx, cfg_field;
    logic [W-1:0] cfg_data;
    logic [3:0]   last_layer;
    logic         start, abort, eng_done;
    logic         busy, sched_done, err, eng_sel, conv_enable, pool_enable;
    logic [3:0]   cur_layer;
    logic [2:0]   step;
    logic [W-1:0] dr, dc, di, dr_out, dc_out, di_out, inaddr, outaddr;

    int n_cmp = 0;
    int n_err = 0;

    cnn_layer_scheduler #(
        .MEMADDRBIT    (W),
        .NUM_LAYERS    (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_field  (cfg_field),
        .cfg_data   (cfg_data),
        .last_layer (last_layer),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .sched_done (sched_done),
        .err        (err),
        .cur_layer  (cur_layer),
        .eng_sel    (eng_sel),
        .conv_enable(conv_enable),
        .pool_enable(pool_enable),
        .eng_done   (eng_done),
        .step       (step),
        .dr         (dr),
        .dc         (dc),
        .di         (di),
        .dr_out     (dr_out),
        .dc_out     (dc_out),
        .di_out     (di_out),
        .inaddr     (inaddr),
        .outaddr    (outaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] idx, input logic [3:0] fld, input logic [W-1:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_field = fld; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    // Enables must be mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) check("enables_exclusive", 32'(conv_enable & pool_enable), 32'd0);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_data = '0;
        last_layer = '0; start = 1'b0; abort = 1'b0; eng_done = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_dr", 32'(dr), 0);
        check("rst_cur_layer", 32'(cur_layer), 0);
        check("rst_conv_en", 32'(conv_enable), 0);

        // Layer 0: conv, step 1, 32x32x3. Layer 1: pool, step 2, dr_out 16.
        wr(4'd0, 4'd0, 14'd2);
        wr(4'd0, 4'd1, 14'd32);
        wr(4'd0, 4'd2, 14'd32);
        wr(4'd0, 4'd3, 14'd3);
        wr(4'd1, 4'd0, 14'd5);
        wr(4'd1, 4'd4, 14'd16);
        wr(4'd5, 4'd1, 14'd77);        // out-of-range index, dropped

        // Two-layer run; start sampled at edge 0.
        last_layer = 4'd1; start = 1'b1;
        tick();                        // edge 0
        start = 1'b0;
        check("t1_busy", 32'(busy), 1);
        check("t1_conv_early", 32'(conv_enable), 0);
        tick();                        // edge 1: LOAD
        check("t1_dr", 32'(dr), 32);
        check("t1_di", 32'(di), 3);
        check("t1_step0", 32'(step), 1);
        check("t1_sel0", 32'(eng_sel), 0);
        tick();                        // edge 2: enable
        check("t1_conv_en", 32'(conv_enable), 1);
        check("t1_pool_off", 32'(pool_enable), 0);
        tick();
        check("t1_conv_pulse", 32'(conv_enable), 0);
        repeat (46) tick();            // edges 4..49
        eng_done = 1'b1;
        tick();                        // edge 50: done edge
        eng_done = 1'b0;
        tick();                        // edge 51
        check("t1_pool_51", 32'(pool_enable), 0);
        tick();                        // edge 52: LOAD layer 1
        check("t1_sel1", 32'(eng_sel), 1);
        check("t1_step1", 32'(step), 2);
        check("t1_dr_out1", 32'(dr_out), 16);
        check("t1_dr1", 32'(dr), 0);
        check("t1_pool_52", 32'(pool_enable), 0);
        tick();                        // edge 53
        check("t1_pool_en", 32'(pool_enable), 1);
        check("t1_conv_off", 32'(conv_enable), 0);
        check("t1_cur1", 32'(cur_layer), 1);
        repeat (5) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("t1_done_early", 32'(sched_done), 0);
        check("t1_busy_hold", 32'(busy), 1);
        tick();
        check("t1_sched_done", 32'(sched_done), 1);
        check("t1_busy_clr", 32'(busy), 0);
        tick();
        check("t1_done_pulse", 32'(sched_done), 0);

        // eng_done already high on WAIT entry: needs a fresh rising edge.
        eng_done = 1'b1; last_layer = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 4'd1; cfg_data = 14'd99;
        tick();
        cfg_we = 1'b0;
        tick();
        check("t2_conv_en", 32'(conv_enable), 1);
        repeat (5) tick();
        check("t2_still_busy", 32'(busy), 1);
        check("t2_no_done", 32'(sched_done), 0);
        eng_done = 1'b0;
        tick();
        eng_done = 1'b1;
        tick();
        tick();
        check("t2_sched_done", 32'(sched_done), 1);
        eng_done = 1'b0;
        tick();

        // Write while busy was dropped; abort beats a same-cycle done edge.
        last_layer = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t3_dr_unchanged", 32'(dr), 32);
        tick();
        tick();
        tick();
        eng_done = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0; eng_done = 1'b0;
        check("t3_busy", 32'(busy), 0);
        check("t3_dr", 32'(dr), 0);
        check("t3_di", 32'(di), 0);
        check("t3_step", 32'(step), 0);
        check("t3_cur", 32'(cur_layer), 0);
        check("t3_no_done", 32'(sched_done), 0);
        tick();
        check("t3_no_done2", 32'(sched_done), 0);
        check("t3_idle", 32'(busy), 0);
        check("t3_no_en", 32'(conv_enable | pool_enable), 0);

        // Out-of-range last_layer is rejected.
        last_layer = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_err", 32'(err), 1);
        check("t4_busy", 32'(busy), 0);
        tick();
        check("t4_err_pulse", 32'(err), 0);
        check("t4_still_idle", 32'(busy), 0);

        // Same-cycle write and start: LOAD sees the new dr.
        last_layer = 4'd0; start = 1'b1;
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 4'd1; cfg_data = 14'd28;
        tick();                        // edge 0: WAIT entry at edge 2
        start = 1'b0; cfg_we = 1'b0;
        tick();
        check("t5_dr", 32'(dr), 28);
        tick();                        // edge 2
        check("t5_conv_en", 32'(conv_enable), 1);
        check("t5_dr_issue", 32'(dr), 28);

`ifdef SCHED_TIMEOUT_EN
        repeat (19) tick();            // edges 3..21
        check("t6_no_err_yet", 32'(err), 0);
        check("t6_busy_yet", 32'(busy), 1);
        tick();                        // edge 22 = WAIT entry + 20
        check("t6_err", 32'(err), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_dr", 32'(dr), 0);
        tick();
        check("t6_err_pulse", 32'(err), 0);
`else
        repeat (100) tick();
        check("t6_busy_forever", 32'(busy), 1);
        check("t6_no_err", 32'(err), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort", 32'(busy), 0);
`endif

        // Reset mid-sequence clears the table too.
        last_layer = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t7_dr_before", 32'(dr), 28);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_busy", 32'(busy), 0);
        check("t7_dr", 32'(dr), 0);
        last_layer = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t7_tbl_cleared_dr", 32'(dr), 0);
        check("t7_tbl_cleared_di", 32'(di), 0);
        tick();
        check("t7_conv_en", 32'(conv_enable), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7_abort", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
